sync_memory: RTL
================

SYNC_MEMORY -- requirements
Module: sync_memory

Interface
REQ-001 SHALL have parameter data_length, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter mem_length, default 512, number of words; need not be a power of 2.
REQ-003 SHALL have parameter init_mode, default 1; 0 = clear every word to 0, 1 = word i holds value i (truncated to data_length).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req  input  1  access request, qualified by ready.
REQ-007 SHALL have port we  input  1  0 = read, 1 = write.
REQ-008 SHALL have port be  input  data_length/8  byte enables for writes; bit k covers wdata[8k+7:8k].
REQ-009 SHALL have port addr  input  $clog2(mem_length)  word address.
REQ-010 SHALL have port wdata  input  data_length  write data.
REQ-011 SHALL have port ready  output  1  high when a request is accepted this cycle.
REQ-012 SHALL have port busy  output  1  high while the init sweep runs.
REQ-013 SHALL have port rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-014 SHALL have port rdata  output  data_length  read data, registered.
REQ-015 SHALL have port err  output  1  one-cycle pulse flagging an out-of-range access.

Function
REQ-016 SHALL implement a two-state FSM: INIT and RUN.
REQ-017 INIT: sweep counter starts at 0 and writes one word per cycle with the init_mode value; busy=1 and ready=0.
REQ-018 INIT SHALL go to RUN the cycle after word mem_length-1 is written; INIT takes exactly mem_length cycles.
REQ-019 RUN SHALL hold busy=0 and ready=1; RUN SHALL be left only by rst.
REQ-020 Accepted access = req & ready; req while busy SHALL be ignored, with no write, no rvalid and no err.
REQ-021 Accepted read SHALL give rvalid=1 and rdata=mem[addr] on the next cycle: 1-cycle latency.
REQ-022 Accepted write SHALL update only the bytes whose be bit is 1; other bytes SHALL be kept; be=0 SHALL leave the word unchanged.
REQ-023 Writes SHALL NOT assert rvalid; rdata SHALL hold its last value across writes and idle cycles.
REQ-024 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-025 Back-to-back reads, one per cycle, SHALL be supported at full throughput.
REQ-026 addr >= mem_length SHALL assert err next cycle and SHALL NOT write memory.
REQ-027 An out-of-range read SHALL also assert rvalid next cycle, with rdata=0.
REQ-028 rvalid and err SHALL be deasserted in every cycle without a qualifying access.

Reset
REQ-029 rst=1 SHALL, at the next edge, set the FSM to INIT, the sweep counter to 0, busy=1, ready=0, rvalid=0, err=0 and rdata=0.
REQ-030 rst asserted mid-sweep or mid-access SHALL restart the sweep from word 0; any pending rvalid or err SHALL be dropped.
REQ-031 Memory contents SHALL be fully reinitialised by every sweep; there is no partial retention across rst.

Verification
REQ-032 Defaults, rst 1 cycle then low -> busy=1 for exactly 512 cycles, then ready=1; read addr 37 -> next cycle rvalid=1, rdata=37.
REQ-033 Write addr 5, wdata=0xAABBCCDD, be=4'b0101, then read 5 next cycle -> rdata=0x00BB00DD (init 5 = 0x00000005, byte0 overwritten).
REQ-034 Consecutive reads of addrs 1,2,3 on 3 cycles -> rvalid high 3 cycles, rdata 1,2,3.
REQ-035 mem_length=300, write addr 310 -> err pulse, no memory change; read addr 310 -> rvalid=1, err=1, rdata=0.
REQ-036 rst at sweep cycle 100, then 512-cycle wait -> busy high for 512 cycles after reset release; read 0 -> 0, read 511 -> 511.
REQ-037 req=1 during busy, we=1, addr 3, wdata 0xFFFFFFFF -> no rvalid or err; after init, read 3 -> 3.

Source files
------------

// File: rtl/sync_memory.sv
// Single-port synchronous word memory with byte enables.
// A post-reset sweep loads every word before accesses are accepted.
module sync_memory #(
  parameter int data_length = 32,
  parameter int mem_length  = 512,
  parameter int init_mode   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          we,
  input  logic [data_length/8-1:0]      be,
  input  logic [$clog2(mem_length)-1:0] addr,
  input  logic [data_length-1:0]        wdata,
  output logic                          ready,
  output logic                          busy,
  output logic                          rvalid,
  output logic [data_length-1:0]        rdata,
  output logic                          err
);

  localparam int aw = $clog2(mem_length);
  localparam int nb = data_length / 8;
  localparam logic [aw:0]   mlen = (aw+1)'(mem_length);
  localparam logic [aw-1:0] last = aw'(mem_length - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q, state_d;
  logic [aw-1:0]          cnt_q;
  logic [data_length-1:0] mem [mem_length];
  logic [data_length-1:0] init_val;
  logic                   acc;
  logic                   oor;

  assign acc = req & ready;
  assign oor = {1'b0, addr} >= mlen;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      INIT: begin
        busy = 1'b1;
        if (cnt_q == last) state_d = RUN;
      end
      RUN: ready = ~rst;
    endcase
  end

  always_comb begin
    init_val = '0;
    if (init_mode != 0) init_val = data_length'(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Out-of-range writes are dropped; the sweep owns the array while busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[cnt_q] <= init_val;
      end else if (acc && we && !oor) begin
        for (int k = 0; k < nb; k++) begin
          if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= acc & ~we;
      err    <= acc & oor;
      if (acc && !we) rdata <= oor ? '0 : mem[addr];
    end
  end

endmodule
